// File: rtl/y_square_pkg.sv
// Shared register-file constants and types for the writeback path.
package y_square_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO holding load results that wait for a free writeback slot.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_load_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one registered register-file write per cycle,
// with a pending-load scoreboard. Optional forwarding ports under WB_BYPASS_EN.
module writeback_unit
    import y_square_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic [2**ADDR_W-1:0] busy,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]    byp_rs1,
    input  logic [ADDR_W-1:0]    byp_rs2,
    output logic                 byp_hit_a,
    output logic                 byp_hit_b,
    output logic [DATA_W-1:0]    byp_data_a,
    output logic [DATA_W-1:0]    byp_data_b,
`endif
    output logic                 wb_en,
    output logic [ADDR_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]    wb_data
);
    localparam int EW = ADDR_W + DATA_W;

    logic                 fifo_full, fifo_empty, fifo_push;
    logic [EW-1:0]        head;
    reg_idx_t             head_rd;
    reg_data_t            head_data;
    logic                 sel_alu, sel_ld;

    logic                 wb_en_q, wb_en_d;
    reg_idx_t             wb_rd_q, wb_rd_d;
    reg_data_t            wb_data_q, wb_data_d;
    logic [2**ADDR_W-1:0] busy_q, busy_d;

    assign ld_ready  = !fifo_full;
    // Loads to r0 complete the handshake but never occupy a queue slot.
    assign fifo_push = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign {head_rd, head_data} = head;

    wb_load_fifo #(.W(EW), .DEPTH(LQ_DEPTH)) u_lq (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (fifo_push),
        .din    ({ld_rd, ld_data}),
        .pop    (sel_ld),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        sel_alu   = alu_valid && (alu_rd != REG_ZERO);
        sel_ld    = !sel_alu && !fifo_empty;
        wb_en_d   = sel_alu || sel_ld;
        wb_rd_d   = REG_ZERO;
        wb_data_d = '0;
        if (sel_alu) begin
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (sel_ld) begin
            wb_rd_d   = head_rd;
            wb_data_d = head_data;
        end
        // Clear first so a same-cycle re-issue to the same register wins.
        busy_d = busy_q;
        if (sel_ld) busy_d[head_rd] = 1'b0;
        if (iss_valid && (iss_rd != REG_ZERO)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= REG_ZERO;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign busy    = busy_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        byp_hit_a  = wb_en_q && (wb_rd_q == byp_rs1) && (byp_rs1 != REG_ZERO);
        byp_hit_b  = wb_en_q && (wb_rd_q == byp_rs2) && (byp_rs2 != REG_ZERO);
        byp_data_a = byp_hit_a ? wb_data_q : '0;
        byp_data_b = byp_hit_b ? wb_data_q : '0;
    end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized checks of writeback_unit against a queue-based reference model.
module tb_writeback_unit;
    localparam int LQ = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_rd = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_rd = '0;
    logic [15:0] ld_data = '0;
    logic        iss_valid = 1'b0;
    logic [2:0]  iss_rd = '0;
    logic [7:0]  busy;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
`ifdef WB_BYPASS_EN
    logic [2:0]  byp_rs1 = '0, byp_rs2 = '0;
    logic        byp_hit_a, byp_hit_b;
    logic [15:0] byp_data_a, byp_data_b;
`endif

    writeback_unit #(.LQ_DEPTH(LQ)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
`ifdef WB_BYPASS_EN
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b),
`endif
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] rd; logic [15:0] data; } ent_t;
    ent_t        mq[$];
    bit          mbusy[8];
    bit          m_en;
    logic [2:0]  m_rd;
    logic [15:0] m_data;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mbusy[i] = 0;
        m_en = 0; m_rd = '0; m_data = '0;
    endtask

    // One clock: apply inputs, predict, clock, then compare at the following negedge.
    task automatic cyc(input bit av, input logic [2:0] ar, input logic [15:0] ad,
                       input bit lv, input logic [2:0] lr, input logic [15:0] ldd,
                       input bit iv, input logic [2:0] ir);
        bit accept;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        iss_valid = iv; iss_rd = ir;
        #1;
        chk("ld_ready", ld_ready, mq.size() < LQ);
        accept = lv && (mq.size() < LQ);
        m_en = 0;
        if (av && ar != 0) begin
            m_en = 1; m_rd = ar; m_data = ad;
        end else if (mq.size() > 0) begin
            ent_t e = mq.pop_front();
            m_en = 1; m_rd = e.rd; m_data = e.data;
            mbusy[e.rd] = 0;
        end
        if (accept && lr != 0) mq.push_back('{rd: lr, data: ldd});
        if (iv && ir != 0) mbusy[ir] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("wb_en", wb_en, m_en);
        if (m_en) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, m_data);
        end
        chk("busy", busy, busy_vec());
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 1);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU only, then ALU to r0 is dropped
        cyc(1, 3, 16'h1234, 0, 0, 0, 0, 0);
        chk("alu_r3_data", wb_data, 16'h1234);
        cyc(1, 0, 16'h9999, 0, 0, 0, 0, 0);
        chk("alu_r0_en", wb_en, 0);

        // ALU and load in the same cycle: ALU first, load next
        cyc(1, 2, 16'hAAAA, 1, 5, 16'h5555, 0, 0);
        chk("conf_rd0", wb_rd, 2);
        idle();
        chk("conf_rd1", wb_rd, 5);
        chk("conf_data1", wb_data, 16'h5555);

        // Backpressure: ALU every cycle fills the queue, one idle slot drains one
        cyc(1, 1, 16'h0001, 1, 6, 16'h0606, 0, 0);
        cyc(1, 1, 16'h0002, 1, 7, 16'h0707, 0, 0);
        cyc(1, 1, 16'h0003, 0, 0, 0, 0, 0);
        chk("bp_full", ld_ready, 0);
        idle();
        chk("bp_drain_rd", wb_rd, 6);
        chk("bp_ready", ld_ready, 1);
        idle();

        // Scoreboard set, clear, and set-wins on re-issue in the clear cycle
        cyc(0, 0, 0, 0, 0, 0, 1, 4);
        chk("sb_set", busy, 8'h10);
        cyc(1, 1, 16'h0011, 1, 4, 16'h4444, 0, 0);
        idle();
        chk("sb_clear", busy, 8'h00);
        cyc(1, 2, 16'h0022, 1, 4, 16'h4545, 1, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 4);
        chk("sb_set_wins", busy, 8'h10);
        idle();

        // Reset in the middle of a drain
        cyc(1, 1, 16'h0101, 1, 3, 16'h3333, 1, 3);
        cyc(1, 1, 16'h0102, 1, 5, 16'h5151, 0, 0);
        alu_valid = 0; ld_valid = 0; iss_valid = 0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_en", wb_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ld_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        idle();

`ifdef WB_BYPASS_EN
        cyc(1, 6, 16'hBEEF, 0, 0, 0, 0, 0);
        byp_rs1 = 6; byp_rs2 = 0;
        #1;
        chk("byp_hit_a", byp_hit_a, 1);
        chk("byp_data_a", byp_data_a, 16'hBEEF);
        chk("byp_hit_b", byp_hit_b, 0);
        idle();
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 2) == 0, 3'($urandom), 16'($urandom),
                ($urandom % 2) == 0, 3'($urandom), 16'($urandom),
                ($urandom % 4) == 0, 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
